ptp_tsu_sc: RTL

Single-clock, parametrised PTP time-stamp unit for the GMII receive path. It performs the following steps:
- detects frame start on the GMII interface and captures the RTC time at that point;
- applies a fixed ingress-latency correction with nanosecond/second carry;
- parses the Ethernet header in-line to identify IEEE 1588 frames;
- queues {sequenceId, messageType, timestamp} entries in a parametrised show-ahead FIFO with overflow accounting.

It replaces the dual-clock TSU wherever the RTC time is already available in the gmii_clk domain.

---
 rtl/ptp_tsu_sc.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ptp_tsu_sc.sv
// GMII RX PTP time-stamp unit: stamps SOP with RTC time, parses 1588 header, queues entries (VLAN via TSU_VLAN_EN).
// Latency: entry written one edge after RX_DV is sampled low; reads are show-ahead; full FIFO drops and counts.
module ptp_tsu_sc_fifo #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          gmii_clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_rdy,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat,
  output logic [AW:0]   level
);
  // Show-ahead FIFO; a write into a full FIFO is still taken when a pop happens on the same edge.
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign rd_vld = (level != '0);
  assign do_rd  = rd_rdy && rd_vld;
  assign wr_rdy = (level != DEPTH) || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      level <= level + (AW+1)'(1);
      else if (do_rd && !do_wr) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge gmii_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

module ptp_tsu_sc #(
  parameter int SEC_W             = 6,
  parameter int FIFO_AW           = 4,
  parameter int INGRESS_OFFSET_NS = 0
) (
  input  logic                gmii_clk,
  input  logic                rst,
  input  logic                gmii_ctrl,
  input  logic [7:0]          gmii_data,
  input  logic [SEC_W+29:0]   rtc_time_in,
  input  logic                q_rd_en,
  output logic                q_rd_valid,
  output logic [63:0]         q_rd_data,
  output logic [FIFO_AW:0]    q_level,
  output logic [15:0]         q_drop_cnt
);
  localparam int          TS_W       = SEC_W + 30;
  localparam logic [30:0] NS_PER_SEC = 31'd1_000_000_000;
  localparam logic [30:0] OFFSET_NS  = 31'(INGRESS_OFFSET_NS);

  typedef enum logic [2:0] {IDLE, PRE, HDR, SKIP, DONE} state_t;

  state_t           state, state_n;
  logic             int_ctrl, ctrl_d, armed, sop;
  logic [7:0]       int_data;
  logic [TS_W-1:0]  ts_raw, ts_corr;
  logic [30:0]      ns_sum;
  logic [29:0]      ns_wrap;
  logic [SEC_W-1:0] sec_raw, sec_inc;
  logic [5:0]       bcnt, bcnt_n, hoff;
  logic [7:0]       et_hi, et_hi_n;
  logic             vlan, vlan_n, et_ptp, et_vlan;
  logic [3:0]       msg_type, msg_type_n;
  logic [15:0]      seq_id, seq_id_n;
  logic             wr_en, wr_rdy;
  logic [63:0]      entry;

  // Input stage is left unreset so a frame still in flight through reset keeps int_ctrl high and stays disarmed.
  always_ff @(posedge gmii_clk) begin
    int_ctrl <= gmii_ctrl;
    int_data <= gmii_data;
    ctrl_d   <= int_ctrl;
  end

  always_ff @(posedge gmii_clk) begin
    if (rst)            armed <= 1'b0;
    else if (!int_ctrl) armed <= 1'b1;
  end

  assign sop = armed && int_ctrl && !ctrl_d;

  assign ns_sum  = {1'b0, ts_raw[29:0]} + OFFSET_NS;
  assign ns_wrap = 30'(ns_sum - NS_PER_SEC);
  assign sec_raw = ts_raw[TS_W-1:30];
  assign sec_inc = sec_raw + SEC_W'(1);

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      ts_raw  <= '0;
      ts_corr <= '0;
    end else begin
      if (state == IDLE && sop) ts_raw <= rtc_time_in;
      if (ns_sum >= NS_PER_SEC) ts_corr <= {sec_inc, ns_wrap};
      else                      ts_corr <= {sec_raw, ns_sum[29:0]};
    end
  end

  assign hoff   = vlan ? 6'd4 : 6'd0;
  assign et_ptp = ({et_hi, int_data} == 16'h88F7);
`ifdef TSU_VLAN_EN
  assign et_vlan = ({et_hi, int_data} == 16'h8100) && !vlan;
`else
  assign et_vlan = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    bcnt_n     = bcnt;
    et_hi_n    = et_hi;
    vlan_n     = vlan;
    msg_type_n = msg_type;
    seq_id_n   = seq_id;
    wr_en      = 1'b0;
    case (state)
      IDLE: if (sop) state_n = PRE;
      PRE: begin
        if (!int_ctrl) state_n = IDLE;
        else if (int_data == 8'hD5) begin
          state_n = HDR;
          bcnt_n  = 6'd0;
          vlan_n  = 1'b0;
        end else if (int_data != 8'h55) state_n = SKIP;
      end
      HDR: begin
        if (!int_ctrl) state_n = IDLE;
        else begin
          bcnt_n = (bcnt == 6'h3F) ? bcnt : bcnt + 6'd1;
          if (bcnt == 6'd12 + hoff) et_hi_n = int_data;
          if (bcnt == 6'd13 + hoff && !et_ptp) begin
            if (et_vlan) vlan_n = 1'b1;
            else         state_n = SKIP;
          end
          if (bcnt == 6'd14 + hoff) msg_type_n = int_data[3:0];
          if (bcnt == 6'd44 + hoff) seq_id_n[15:8] = int_data;
          if (bcnt == 6'd45 + hoff) begin
            seq_id_n[7:0] = int_data;
            state_n       = DONE;
          end
        end
      end
      SKIP: if (!int_ctrl) state_n = IDLE;
      DONE: if (!int_ctrl) begin
        wr_en   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk) begin
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      et_hi    <= '0;
      vlan     <= 1'b0;
      msg_type <= '0;
      seq_id   <= '0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      et_hi    <= et_hi_n;
      vlan     <= vlan_n;
      msg_type <= msg_type_n;
      seq_id   <= seq_id_n;
    end
  end

  always_comb begin
    entry              = '0;
    entry[63:48]       = seq_id;
    entry[47:44]       = msg_type;
    entry[TS_W-1:0]    = ts_corr;
  end

  ptp_tsu_sc_fifo #(.DW(64), .AW(FIFO_AW)) u_fifo (
    .gmii_clk (gmii_clk),
    .rst      (rst),
    .wr_vld   (wr_en),
    .wr_dat   (entry),
    .wr_rdy   (wr_rdy),
    .rd_rdy   (q_rd_en),
    .rd_vld   (q_rd_valid),
    .rd_dat   (q_rd_data),
    .level    (q_level)
  );

  always_ff @(posedge gmii_clk) begin
    if (rst) q_drop_cnt <= '0;
    else if (wr_en && !wr_rdy && q_drop_cnt != 16'hFFFF) q_drop_cnt <= q_drop_cnt + 16'd1;
  end
endmodule
